// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   rx_state_e    - receiver FSM states
//   DBITS_*       - data_bit_num encodings (00=5 .. 11=8 data bits)
//   PARITY_*      - parity_type encodings
//   STOP_*        - stop_bit_num encodings
//   data_bits()   - converts a data_bit_num code into a bit count (5..8)
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

  // Number of data bits carried by a frame for a given data_bit_num code.
  function automatic logic [3:0] data_bits(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input.
//   clk   - system clock
//   rst   - synchronous, active-high reset (loads RESET_VAL into both flops)
//   d_i   - asynchronous input
//   q_o   - synchronized output, two clk cycles behind d_i
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Both stages reset to the line's idle level so a reset never looks like
  // an edge on the synchronized side.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with configurable frame format.
//   clk, rst          - system clock, synchronous active-high reset
//   rx                - asynchronous serial line (idle high)
//   rx_tick           - one-clk pulse, OVERSAMPLE pulses per bit period
//   data_bit_num_i    - 00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i       - parity bit present
//   parity_type_i     - 0 = even, 1 = odd
//   stop_bit_num_i    - 0 = one stop bit, 1 = two stop bits
//   rx_read_i         - register block has consumed rx_data_o
//   rx_data_o         - last received word, zero-extended to DATA_W
//   rx_done_o         - one-clk pulse when a new word is delivered
//   parity_err_o      - parity mismatch on the last frame
//   frame_err_o       - a stop bit sampled low on the last frame
//   overrun_err_o     - sticky: a frame completed while the previous was unread
//   rts_n             - 0 = ready to receive, 1 = holding unread data
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              rx_tick,
  input  logic [1:0]        data_bit_num_i,
  input  logic              parity_en_i,
  input  logic              parity_type_i,
  input  logic              stop_bit_num_i,
  input  logic              rx_read_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_done_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_err_o,
  output logic              rts_n
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic [2:0]    last_bit_q, last_bit_d;
  logic          pen_q, pen_d;
  logic          ptype_q, ptype_d;
  logic          stop2_q, stop2_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          perr_out_q, perr_out_d;
  logic          ferr_out_q, ferr_out_d;
  logic          ovr_q, ovr_d;
  logic          rts_q, rts_d;
  logic          complete;
  logic          mid_bit;

  assign mid_bit = rx_tick && (tcnt_q == FULL_M1);

  // Frame FSM plus the delivery/handshake logic. The config inputs are
  // captured when the start edge is seen so that reconfiguring mid-frame
  // only affects the next frame. Data bits are stored by index rather than
  // shifted, which leaves them LSB-aligned for any width from 5 to 8.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    last_bit_d = last_bit_q;
    pen_d      = pen_q;
    ptype_d    = ptype_q;
    stop2_d    = stop2_q;
    data_d     = data_q;
    done_d     = 1'b0;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;
    rts_d      = rts_q;
    complete   = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (rx_tick && !rx_s) begin
          state_d    = RX_START;
          tcnt_d     = '0;
          bcnt_d     = '0;
          shreg_d    = '0;
          par_d      = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          last_bit_d = 3'(data_bits(data_bit_num_i) - 4'd1);
          pen_d      = parity_en_i;
          ptype_d    = parity_type_i;
          stop2_d    = stop_bit_num_i;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (tcnt_q == HALF_M1) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (mid_bit) begin
          tcnt_d          = '0;
          shreg_d[bcnt_q] = rx_s;
          par_d           = par_q ^ rx_s;
          if (bcnt_q == last_bit_q) begin
            bcnt_d  = '0;
            state_d = pen_q ? RX_PARITY : RX_STOP;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end else if (rx_tick) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (mid_bit) begin
          tcnt_d  = '0;
          bcnt_d  = '0;
          perr_d  = (par_q ^ rx_s) != ptype_q;
          state_d = RX_STOP;
        end else if (rx_tick) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (mid_bit) begin
          tcnt_d = '0;
          if (!rx_s) begin
            ferr_d = 1'b1;
          end
          // Leave right after the last stop sample so a following start
          // bit is never missed.
          if (bcnt_q[0] == stop2_q) begin
            bcnt_d   = '0;
            state_d  = RX_IDLE;
            complete = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end else if (rx_tick) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase

    // A completing frame takes priority over a read in the same cycle, so
    // the fresh word is never reported as consumed.
    if (complete) begin
      data_d     = shreg_q;
      done_d     = 1'b1;
      perr_out_d = perr_q;
      ferr_out_d = ferr_q | ~rx_s;
      rts_d      = 1'b1;
      if (rts_q) begin
        ovr_d = 1'b1;
      end
    end else if (rx_read_i && rts_q) begin
      rts_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      last_bit_q <= '0;
      pen_q      <= 1'b0;
      ptype_q    <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      rts_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      last_bit_q <= last_bit_d;
      pen_q      <= pen_d;
      ptype_q    <= ptype_d;
      stop2_q    <= stop2_d;
      data_q     <= data_d;
      done_q     <= done_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
      rts_q      <= rts_d;
    end
  end

  assign rx_data_o     = DATA_W'(data_q);
  assign rx_done_o     = done_q;
  assign parity_err_o  = perr_out_q;
  assign frame_err_o   = ferr_out_q;
  assign overrun_err_o = ovr_q;
  assign rts_n         = rts_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (OVERSAMPLE=16, DATA_W=32).
module tb_uart_rx;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        rx_tick;
  logic [1:0]  data_bit_num_i;
  logic        parity_en_i;
  logic        parity_type_i;
  logic        stop_bit_num_i;
  logic        rx_read_i;
  logic [31:0] rx_data_o;
  logic        rx_done_o;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_err_o;
  logic        rts_n;

  int checks;
  int failures;
  int doneCount;

  uart_rx #(.OVERSAMPLE(16), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .rx_tick        (rx_tick),
    .data_bit_num_i (data_bit_num_i),
    .parity_en_i    (parity_en_i),
    .parity_type_i  (parity_type_i),
    .stop_bit_num_i (stop_bit_num_i),
    .rx_read_i      (rx_read_i),
    .rx_data_o      (rx_data_o),
    .rx_done_o      (rx_done_o),
    .parity_err_o   (parity_err_o),
    .frame_err_o    (frame_err_o),
    .overrun_err_o  (overrun_err_o),
    .rts_n          (rts_n)
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle rx_done_o is high adds one, so a single-cycle pulse per
  // frame shows up as exactly one increment per frame.
  always @(negedge clk) begin
    if (rx_done_o === 1'b1) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bit period on the line: 16 rx_tick pulses, one every other clock.
  task automatic sendBit(input logic b);
    rx = b;
    repeat (16) begin
      @(negedge clk);
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
    end
  endtask

  // A complete frame followed by one idle bit period.
  task automatic applyStimulus(input logic [7:0] data, input int nbits, input logic parEn,
                               input logic parBit, input logic stopA, input logic twoStops,
                               input logic stopB);
    sendBit(1'b0);
    for (int i = 0; i < nbits; i++) sendBit(data[i]);
    if (parEn) sendBit(parBit);
    sendBit(stopA);
    if (twoStops) sendBit(stopB);
    sendBit(1'b1);
  endtask

  task automatic pulseRead();
    @(negedge clk);
    rx_read_i = 1'b1;
    @(negedge clk);
    rx_read_i = 1'b0;
  endtask

  task automatic setConfig(input logic [1:0] dbits, input logic pen, input logic ptype, input logic stops);
    @(negedge clk);
    data_bit_num_i = dbits;
    parity_en_i    = pen;
    parity_type_i  = ptype;
    stop_bit_num_i = stops;
  endtask

  initial begin
    int baseCount;
    checks         = 0;
    failures       = 0;
    doneCount      = 0;
    rst            = 1'b1;
    rx             = 1'b1;
    rx_tick        = 1'b0;
    rx_read_i      = 1'b0;
    data_bit_num_i = 2'b11;
    parity_en_i    = 1'b0;
    parity_type_i  = 1'b0;
    stop_bit_num_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_data", rx_data_o, 32'h0);
    checkOutput("rst_done", {31'b0, rx_done_o}, 32'h0);
    checkOutput("rst_perr", {31'b0, parity_err_o}, 32'h0);
    checkOutput("rst_ferr", {31'b0, frame_err_o}, 32'h0);
    checkOutput("rst_ovr", {31'b0, overrun_err_o}, 32'h0);
    checkOutput("rst_rts", {31'b0, rts_n}, 32'h0);

    $display("[TB] 8N1 0xA5");
    setConfig(2'b11, 1'b0, 1'b0, 1'b0);
    sendBit(1'b1);
    applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("a5_done_cnt", doneCount, 32'd1);
    checkOutput("a5_data", rx_data_o, 32'h000000A5);
    checkOutput("a5_perr", {31'b0, parity_err_o}, 32'h0);
    checkOutput("a5_ferr", {31'b0, frame_err_o}, 32'h0);
    checkOutput("a5_ovr", {31'b0, overrun_err_o}, 32'h0);
    checkOutput("a5_rts", {31'b0, rts_n}, 32'h1);
    pulseRead();
    checkOutput("a5_rts_after_read", {31'b0, rts_n}, 32'h0);

    $display("[TB] 7O1 0x35 with wrong then correct parity");
    setConfig(2'b10, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("p_bad_done_cnt", doneCount, 32'd2);
    checkOutput("p_bad_data", rx_data_o, 32'h00000035);
    checkOutput("p_bad_perr", {31'b0, parity_err_o}, 32'h1);
    pulseRead();
    applyStimulus(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("p_ok_done_cnt", doneCount, 32'd3);
    checkOutput("p_ok_data", rx_data_o, 32'h00000035);
    checkOutput("p_ok_perr", {31'b0, parity_err_o}, 32'h0);
    checkOutput("p_ok_ovr", {31'b0, overrun_err_o}, 32'h0);
    pulseRead();

    $display("[TB] 5N2 0x1B with second stop bit low");
    setConfig(2'b00, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h1B, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("f_done_cnt", doneCount, 32'd4);
    checkOutput("f_data", rx_data_o, 32'h0000001B);
    checkOutput("f_ferr", {31'b0, frame_err_o}, 32'h1);
    checkOutput("f_perr", {31'b0, parity_err_o}, 32'h0);
    pulseRead();

    $display("[TB] 4-tick glitch then 0x3C");
    setConfig(2'b11, 1'b0, 1'b0, 1'b0);
    sendBit(1'b1);
    rx = 1'b0;
    repeat (4) begin
      @(negedge clk);
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
    end
    sendBit(1'b1);
    sendBit(1'b1);
    checkOutput("g_done_cnt", doneCount, 32'd4);
    checkOutput("g_rts", {31'b0, rts_n}, 32'h0);
    applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("g_ok_done_cnt", doneCount, 32'd5);
    checkOutput("g_ok_data", rx_data_o, 32'h0000003C);
    checkOutput("g_ok_ferr", {31'b0, frame_err_o}, 32'h0);
    pulseRead();

    $display("[TB] overrun 0x11 then 0x22");
    applyStimulus(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("o1_data", rx_data_o, 32'h00000011);
    checkOutput("o1_ovr", {31'b0, overrun_err_o}, 32'h0);
    applyStimulus(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("o2_done_cnt", doneCount, 32'd7);
    checkOutput("o2_data", rx_data_o, 32'h00000022);
    checkOutput("o2_ovr", {31'b0, overrun_err_o}, 32'h1);
    checkOutput("o2_rts", {31'b0, rts_n}, 32'h1);
    pulseRead();
    checkOutput("o_read_ovr", {31'b0, overrun_err_o}, 32'h0);
    checkOutput("o_read_rts", {31'b0, rts_n}, 32'h0);

    $display("[TB] reset during DATA of 0x5A, then 0x81");
    applyStimulus(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    baseCount = doneCount;
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("r_done_cnt", doneCount, 32'(baseCount));
    checkOutput("r_data", rx_data_o, 32'h0);
    checkOutput("r_rts", {31'b0, rts_n}, 32'h0);
    checkOutput("r_ovr", {31'b0, overrun_err_o}, 32'h0);
    checkOutput("r_ferr", {31'b0, frame_err_o}, 32'h0);
    sendBit(1'b1);
    applyStimulus(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("r_ok_done_cnt", doneCount, 32'(baseCount + 1));
    checkOutput("r_ok_data", rx_data_o, 32'h00000081);
    checkOutput("r_ok_rts", {31'b0, rts_n}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
